app_controller: RTL
===================

// Module: app_controller
// PURPOSE
// - Parametrised successor to the fixed 4-app menu/state controller and final output mux.
// - Owns the app lifecycle: menu select -> init -> run -> game-over -> menu, for NUM_APPS apps.
// - Routes OLED pixel data and the 7-seg an/seg outputs from the active source into one registered output set.
// - Sits between the app blocks (basic, pokemon, potion, ...) and Oled_Display / the seven-segment pins.
// PARAMETERS
// - NUM_APPS      4     number of selectable apps, >=2
// - PIX_W         16    OLED pixel width
// - INIT_TIMEOUT  2000  ticks to wait for app_ready before aborting to MENU
// - OVER_TICKS    3000  ticks the game-over screen is held
// - ABORT_WINDOW  500   ticks allowed between two btn_c pulses for abort (APP_ABORT_EN only)
// PORTS
// - clk         in   1               system clock
// - rst_n       in   1               reset, asynchronous, active-low
// - tick        in   1               1 kHz enable, one clk wide; all timers count on it
// - btn_c/u/d   in   1 each          single-pulse buttons, one clk wide
// - app_ready   in   NUM_APPS        per-app init done, level
// - app_ended   in   NUM_APPS        per-app finished, level or pulse
// - oled_menu   in   PIX_W           menu pixel
// - oled_over   in   PIX_W           game-over pixel
// - oled_app    in   NUM_APPS*PIX_W  app pixels, app i at [i*PIX_W +: PIX_W]
// - an_app      in   NUM_APPS*4      per-app anodes
// - seg_app     in   NUM_APPS*8      per-app segments
// - state       out  2               MENU=0, INIT=1, RUN=2, OVER=3
// - sel         out  $clog2(NUM_APPS) highlighted/active app
// - app_init    out  NUM_APPS        one-hot, high throughout INIT for sel, else 0
// - app_run     out  NUM_APPS        one-hot, high throughout RUN for sel, else 0
// - oled_data   out  PIX_W           registered pixel out
// - an          out  4               registered anodes
// - seg         out  8               registered segments
// BEHAVIOUR
// - Reset: state=MENU, sel=0, app_init=0, app_run=0, timers=0, oled_data=0, an=4'hF, seg=8'hFF.
// - MENU: btn_u gives sel-1, wrapping 0->NUM_APPS-1. btn_d gives sel+1, wrapping NUM_APPS-1->0.
//   - btn_u and btn_d in the same cycle: no move.
//   - btn_c: go to INIT next clk and clear the timer. sel does not move on the btn_c cycle.
// - INIT: app_ready[sel]=1 goes to RUN. If the timer reaches INIT_TIMEOUT ticks first, go to MENU.
//   - If ready and timeout occur in the same cycle, ready wins.
//   - btn_u, btn_d and app_ended are ignored.
// - RUN: app_ended[sel] goes to OVER and clears the timer. Other apps' ended bits are ignored.
//   - Buttons are not consumed here; apps see them directly.
// - OVER: go to MENU after OVER_TICKS ticks or on btn_c, whichever comes first. sel is retained.
// - Output source by state:
//   - MENU: oled_menu, an=4'hF, seg=8'hFF.
//   - INIT: PIX_W'h0, an=4'hF, seg=8'hFF.
//   - RUN: app sel.
//   - OVER: oled_over, with an/seg from app sel so the score stays shown.
// - Output registers load every clk. oled_data/an/seg lag their sources by 1 clk, state changes included.
// - app_init/app_run/state/sel are registered and change on the clk after the causing event.
// - Timers saturate and never wrap. rst_n asserted mid-operation: immediate return to reset values.
// CONFIGURATION
// - APP_ABORT_EN defined:
//   - In RUN, two btn_c pulses within ABORT_WINDOW ticks return to MENU without passing through OVER.
//   - app_ended in the same cycle as the second pulse wins (goes to OVER).
//   - A first pulse older than ABORT_WINDOW is forgotten.
// - APP_ABORT_EN undefined: btn_c is ignored in RUN and the abort timer logic is absent.
// STRUCTURE
// - Package app_ctrl_pkg:
//   - state encodings ST_MENU, ST_INIT, ST_RUN, ST_OVER.
//   - blank constants AN_OFF=4'hF, SEG_OFF=8'hFF.
// - Sub-module app_out_mux: combinational source select plus output register.
//   - Inputs: state and sel.
//   - Instantiated once.
// - FSM, sel counter and tick timers stay in app_controller.
// TESTING
// - Reset, NUM_APPS=4: hold rst_n=0 -> state=0, sel=0, an=F, seg=FF, oled_data=0. Release, then 3x btn_u -> sel=1.
// - Wrap: 4x btn_d from sel=0 -> sel=0. btn_u and btn_d same clk -> sel unchanged.
// - Launch app 2: btn_c -> state=1, app_init=4'b0100. app_ready[2]=1 -> state=2, app_run=4'b0100.
//   - oled_app[2] value 16'hF800 reaches oled_data 1 clk after the state change.
// - Init timeout, INIT_TIMEOUT=5: no app_ready -> MENU after the 5th tick. ready on the 5th tick -> RUN.
// - End: app_ended[1] while sel=2 in RUN -> stays RUN. app_ended[2] -> OVER, an/seg still app 2.
//   - MENU after OVER_TICKS ticks, or on an early btn_c.
// - APP_ABORT_EN, ABORT_WINDOW=3: btn_c, btn_c 2 ticks apart in RUN -> MENU. 4 ticks apart -> stays RUN.

Source files
------------

// File: rtl/app_ctrl_pkg.sv
// Shared encodings and blank-display constants for the app controller.
package app_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_MENU = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_OVER = 2'd3
  } app_state_e;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/app_out_mux.sv
// Selects the OLED / seven-segment source for the current state and registers it,
// so every output lags its source (and any state change) by exactly one clock.
module app_out_mux
  import app_ctrl_pkg::*;
#(
  parameter int NUM_APPS = 4,
  parameter int PIX_W    = 16,
  parameter int SW       = $clog2(NUM_APPS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  app_state_e                state,
  input  logic [SW-1:0]             sel,
  input  logic [PIX_W-1:0]          oled_menu,
  input  logic [PIX_W-1:0]          oled_over,
  input  logic [NUM_APPS*PIX_W-1:0] oled_app,
  input  logic [NUM_APPS*4-1:0]     an_app,
  input  logic [NUM_APPS*8-1:0]     seg_app,
  output logic [PIX_W-1:0]          oled_data,
  output logic [3:0]                an,
  output logic [7:0]                seg
);

  logic [PIX_W-1:0] pix_next;
  logic [3:0]       an_next;
  logic [7:0]       seg_next;

  always_comb begin
    pix_next = oled_menu;
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    case (state)
      ST_MENU: pix_next = oled_menu;
      ST_INIT: pix_next = '0;
      ST_RUN: begin
        pix_next = oled_app[int'(sel)*PIX_W +: PIX_W];
        an_next  = an_app[int'(sel)*4 +: 4];
        seg_next = seg_app[int'(sel)*8 +: 8];
      end
      // Game-over screen keeps the app's score on the seven-segment display.
      ST_OVER: begin
        pix_next = oled_over;
        an_next  = an_app[int'(sel)*4 +: 4];
        seg_next = seg_app[int'(sel)*8 +: 8];
      end
      default: pix_next = oled_menu;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oled_data <= '0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
    end else begin
      oled_data <= pix_next;
      an        <= an_next;
      seg       <= seg_next;
    end
  end

endmodule

// File: rtl/app_controller.sv
// App lifecycle FSM (menu -> init -> run -> game-over) plus output routing.
// Optional double-press abort from RUN is enabled by defining APP_ABORT_EN.
module app_controller
  import app_ctrl_pkg::*;
#(
  parameter int NUM_APPS     = 4,
  parameter int PIX_W        = 16,
  parameter int INIT_TIMEOUT = 2000,
  parameter int OVER_TICKS   = 3000,
  parameter int ABORT_WINDOW = 500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick,
  input  logic                        btn_c,
  input  logic                        btn_u,
  input  logic                        btn_d,
  input  logic [NUM_APPS-1:0]         app_ready,
  input  logic [NUM_APPS-1:0]         app_ended,
  input  logic [PIX_W-1:0]            oled_menu,
  input  logic [PIX_W-1:0]            oled_over,
  input  logic [NUM_APPS*PIX_W-1:0]   oled_app,
  input  logic [NUM_APPS*4-1:0]       an_app,
  input  logic [NUM_APPS*8-1:0]       seg_app,
  output logic [1:0]                  state,
  output logic [$clog2(NUM_APPS)-1:0] sel,
  output logic [NUM_APPS-1:0]         app_init,
  output logic [NUM_APPS-1:0]         app_run,
  output logic [PIX_W-1:0]            oled_data,
  output logic [3:0]                  an,
  output logic [7:0]                  seg
);

  localparam int SW   = $clog2(NUM_APPS);
  localparam int TMAX = (INIT_TIMEOUT > OVER_TICKS) ? INIT_TIMEOUT : OVER_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  app_state_e          st;
  logic [TW-1:0]       timer;
  logic [TW-1:0]       timer_sat;
  logic [NUM_APPS-1:0] sel_onehot;
  logic                abort_hit;

  assign state      = st;
  assign sel_onehot = NUM_APPS'(1) << sel;
  // Timer only advances on tick and holds at all-ones instead of wrapping.
  assign timer_sat  = (tick && (timer != '1)) ? timer + 1'b1 : timer;

`ifdef APP_ABORT_EN
  localparam int AW = $clog2(ABORT_WINDOW + 1);
  logic          armed;
  logic [AW-1:0] abort_cnt;

  assign abort_hit = btn_c && armed;

  // A first btn_c arms the window; it is forgotten once more than ABORT_WINDOW ticks pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      abort_cnt <= '0;
    end else if (st != ST_RUN) begin
      armed     <= 1'b0;
      abort_cnt <= '0;
    end else if (btn_c) begin
      armed     <= !armed;
      abort_cnt <= '0;
    end else if (armed && tick) begin
      if (abort_cnt >= AW'(ABORT_WINDOW)) armed <= 1'b0;
      else abort_cnt <= abort_cnt + 1'b1;
    end
  end
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_MENU;
      sel      <= '0;
      timer    <= '0;
      app_init <= '0;
      app_run  <= '0;
    end else begin
      timer <= timer_sat;
      case (st)
        ST_MENU: begin
          if (btn_c) begin
            st       <= ST_INIT;
            timer    <= '0;
            app_init <= sel_onehot;
          end else if (btn_u && !btn_d) begin
            sel <= (sel == '0) ? SW'(NUM_APPS - 1) : sel - 1'b1;
          end else if (btn_d && !btn_u) begin
            sel <= (sel == SW'(NUM_APPS - 1)) ? '0 : sel + 1'b1;
          end
        end
        ST_INIT: begin
          if (app_ready[sel]) begin
            st       <= ST_RUN;
            app_init <= '0;
            app_run  <= sel_onehot;
          end else if (tick && (timer >= TW'(INIT_TIMEOUT - 1))) begin
            st       <= ST_MENU;
            app_init <= '0;
          end
        end
        ST_RUN: begin
          if (app_ended[sel]) begin
            st      <= ST_OVER;
            timer   <= '0;
            app_run <= '0;
          end else if (abort_hit) begin
            st      <= ST_MENU;
            app_run <= '0;
          end
        end
        ST_OVER: begin
          if (btn_c || (tick && (timer >= TW'(OVER_TICKS - 1)))) st <= ST_MENU;
        end
        default: st <= ST_MENU;
      endcase
    end
  end

  app_out_mux #(
    .NUM_APPS(NUM_APPS),
    .PIX_W   (PIX_W),
    .SW      (SW)
  ) u_out_mux (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (st),
    .sel      (sel),
    .oled_menu(oled_menu),
    .oled_over(oled_over),
    .oled_app (oled_app),
    .an_app   (an_app),
    .seg_app  (seg_app),
    .oled_data(oled_data),
    .an       (an),
    .seg      (seg)
  );

endmodule
